// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot (or all-zero) grant.
// Feeds an 8-to-3 encoder: grant is its data input, grant_valid its enable.
// Supports grant hold until release (done / request drop) and a hold timeout.
module rr_onehot_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(N);
    // Counter only needs to reach MAX_HOLD-1; it saturates when there is no limit.
    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit HasLimit = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HoldLast = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [IW-1:0] IdxLast = IW'(N - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [IW-1:0] ptr_rel;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          release_grant;

    // Pointer the owner would leave behind on release: owner becomes lowest priority.
    always_comb begin
        ptr_rel  = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        pick_ptr = (state_q == StGrant) ? ptr_rel : ptr_q;
    end

    // Rotating priority scan: first set request at or after pick_ptr, wrapping at N.
    always_comb begin
        logic [IW-1:0] scan_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        // Scan downward so the closest index to pick_ptr is written last and wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            scan_idx = IW'((int'(pick_ptr) + i) % int'(N));
            if (req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Owner gives up the grant on done, request drop, or hold timeout.
    always_comb begin
        release_grant = done | ~req[idx_q] | (HasLimit && (hold_q == HoldLast));
    end

    // Next-state: arbitration, hold/release, and enable override.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (en && pick_found) begin
                    state_d = StGrant;
                    grant_d = N'(1) << pick_idx;
                    valid_d = 1'b1;
                    idx_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (!en) begin
                    state_d = StIdle;
                    grant_d = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                    hold_d  = '0;
                end else if (release_grant) begin
                    ptr_d  = ptr_rel;
                    hold_d = '0;
                    if (pick_found) begin
                        grant_d = N'(1) << pick_idx;
                        valid_d = 1'b1;
                        idx_d   = pick_idx;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                valid_d = 1'b0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State registers with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (N=8, MAX_HOLD=4).
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;

    int checks = 0;
    int errors = 0;

    rr_onehot_arbiter #(
        .N        (8),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected grant plus the valid and index values that must accompany it.
    task automatic expect_grant(input string tag, input logic [7:0] exp);
        logic [2:0] ei;
        ei = 3'd0;
        for (int i = 0; i < 8; i++) if (exp[i]) ei = 3'(i);
        check({tag, ".grant"}, {24'd0, grant}, {24'd0, exp});
        check({tag, ".valid"}, {31'd0, grant_valid}, {31'd0, |exp});
        check({tag, ".idx"}, {29'd0, grant_idx}, {29'd0, ei});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        expect_grant("reset", 8'h00);

        // 1: basic grant, then back-to-back handoff on done
        en  = 1'b1;
        req = 8'h05;
        tick();
        expect_grant("t1.first", 8'h01);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("t1.handoff", 8'h04);
        req = 8'h00;
        tick();
        expect_grant("t1.idle", 8'h00);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("t1.done_idle", 8'h00);

        // 2: full rotation with done every grant cycle
        do_reset();
        req = 8'hFF;
        tick();
        expect_grant("t2.start", 8'h01);
        done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            expect_grant($sformatf("t2.rot%0d", k), 8'h01 << ((k + 1) % 8));
        end
        done = 1'b0;

        // 3: hold timeout, 4 cycles each
        do_reset();
        req = 8'h03;
        for (int k = 0; k < 12; k++) begin
            tick();
            expect_grant($sformatf("t3.c%0d", k), ((k / 4) % 2 == 0) ? 8'h01 : 8'h02);
        end

        // 4: owner 2 drops request; ptr=3 finds 7 before 0
        do_reset();
        req = 8'h04;
        tick();
        expect_grant("t4.own2", 8'h04);
        req = 8'h81;
        tick();
        expect_grant("t4.drop", 8'h80);
        req = 8'h83;
        tick();
        expect_grant("t4.keep", 8'h80);

        // 5: enable gating and pointer retention
        do_reset();
        en  = 1'b0;
        req = 8'hFF;
        tick();
        tick();
        expect_grant("t5.en0", 8'h00);
        en  = 1'b1;
        req = 8'h10;
        tick();
        expect_grant("t5.own4", 8'h10);
        req  = 8'h30;
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("t5.own5", 8'h20);
        en  = 1'b0;
        req = 8'hFF;
        tick();
        expect_grant("t5.drop_en", 8'h00);
        en = 1'b1;
        tick();
        expect_grant("t5.reen", 8'h20);

        // 6: reset mid-grant, pointer back to 0
        req  = 8'h40;
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("t6.own6", 8'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_grant("t6.rst", 8'h00);
        req = 8'hC0;
        tick();
        expect_grant("t6.after", 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
